button_event_bank: RTL
======================

# button_event_bank

Parametrised, multi-channel successor to the two-state press detector. Takes `N_BTN` already double-flopped pushbutton inputs and debounces each channel independently with per-channel normally-closed polarity. It classifies every press as short or long, and reports results as one-cycle pulses, level `held` status and sticky flags that software/FSM consumers clear explicitly. It sits between the input synchronisers and the alarm-clock control FSM (set/snooze/mode buttons).

## Interface
- `N_BTN`, 4: number of independent button channels (≥1).
- `DEBOUNCE_CYCLES`, 4: consecutive identical samples required to accept a press or a release (≥1).
- `LONG_CYCLES`, 16: debounced-hold cycles after which a press counts as long (≥2).
- `clk` in 1: single clock domain; all state is updated on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `btn_raw` in N_BTN: synchronised button levels.
- `nc_mask` in N_BTN: 1 = channel is normally closed. The effective level is `btn_raw ^ nc_mask`; 1 means pressed.
- `clear` in N_BTN: synchronous clear of that channel's sticky flags.
- `held` out N_BTN: debounced pressed level.
- `press_pulse` out N_BTN: one-cycle pulse on release of a short press.
- `long_pulse` out N_BTN: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `press_sticky` out N_BTN: set by `press_pulse`, cleared by `clear`.
- `long_sticky` out N_BTN: set by `long_pulse`, cleared by `clear`.

## Operation
- Each channel runs the same FSM, all channels in parallel. Every output is registered.
- Per-channel state:
  - FSM state.
  - `deb_cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - `hold_cnt`, width `$clog2(LONG_CYCLES+1)`, saturating.
  - `is_long` bit.
- `p` = effective level of the channel.
- States and transitions:
  - IDLE:
    - `p`=1 → DEB_DN with `deb_cnt`=1.
    - If `DEBOUNCE_CYCLES`=1, go straight to HELD.
  - DEB_DN:
    - `p`=0 → IDLE (bounce rejected, no output).
    - `p`=1 → increment; at `DEBOUNCE_CYCLES` → HELD with `hold_cnt`=0, `is_long`=0, `held`←1.
  - HELD:
    - `p`=1 → `hold_cnt`++.
    - When `hold_cnt` reaches `LONG_CYCLES` → LONG, `long_pulse`←1 for one cycle, `is_long`←1.
    - `p`=0 → DEB_UP with `deb_cnt`=1.
  - LONG:
    - `p`=0 → DEB_UP with `deb_cnt`=1.
    - Otherwise stay; `hold_cnt` saturates.
  - DEB_UP:
    - `p`=1 → return to HELD, or to LONG if `is_long`; `hold_cnt` resumes from its frozen value.
    - `p`=0 → increment; at `DEBOUNCE_CYCLES` → IDLE, `held`←0, and `press_pulse`←1 for one cycle only if `is_long`=0.
    - `held` stays 1 throughout DEB_UP.
- Outcome per press: a press produces exactly one of `press_pulse` or `long_pulse`, never both.
- Sticky flags:
  - Set on the same edge the pulse is registered.
  - `clear` and a set in the same cycle → the set wins.
  - `clear` only affects stickies; it does not touch the FSM.
- `nc_mask` is quasi-static. A change is treated as an edge on `p` and debounced like any other input.

## Timing
- Reset: every state register goes to IDLE, all counters to 0, and all outputs to 0 immediately and asynchronously. This includes reset asserted mid-press. After release of reset, a button already held is seen as a fresh press and debounced from zero.
- Press latency: `held` rises on the edge that takes the `DEBOUNCE_CYCLES`-th consecutive `p`=1 sample.
- Long latency: `long_pulse` is high in the cycle after `DEBOUNCE_CYCLES + LONG_CYCLES` consecutive 1-samples, assuming no release glitches.
- Release latency: `held` falls and `press_pulse` rises on the edge that takes the `DEBOUNCE_CYCLES`-th consecutive 0-sample.
- Pulses are exactly one cycle wide. No pulse is ever emitted from IDLE or DEB_DN.

## Structure
- Package `button_pkg`:
  - `btn_state_t` enum: IDLE, DEB_DN, HELD, LONG, DEB_UP.
  - Counter-width helper localparams.
- Sub-module `button_channel`: one FSM plus its counters and sticky flops. The top level is a generate loop over `N_BTN` with the XOR polarity stage.
- Sticky flags are plain flip-flops, not latches.

## Test plan
All scenarios use `N_BTN`=2, `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=16.
1. Reset with inputs toggling → all outputs 0. Deassert reset while ch0 is held high → `held[0]` rises on the 4th sample after release of reset.
2. Glitch: ch0 high 3 cycles then low → `held`, both pulses and both stickies stay 0.
3. Short press: ch0 high 10 cycles, then low →
   - `held[0]` goes 1 after the 4th high sample.
   - `press_pulse[0]` lasts one cycle at the 4th low sample, `press_sticky[0]`=1.
   - `long_pulse[0]` stays 0.
4. Long press: ch0 high 30 cycles, then low →
   - `long_pulse[0]` fires once at sample 20 and `long_sticky[0]`=1.
   - No `press_pulse` on release.
   - A 2-cycle low glitch at sample 25 does not end the press.
5. NC channel: `nc_mask`=2'b10, `btn_raw[1]` idle 1, then 0 for 8 cycles → only `press_pulse[1]` fires.
6. Sticky clear race: assert `clear[0]` in the same cycle as `press_pulse[0]` → `press_sticky[0]` stays 1. `clear[0]` one cycle later → 0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the pushbutton event bank.
package button_pkg;

  // Per-channel press-classification FSM states.
  typedef enum logic [2:0] {
    IDLE,
    DEB_DN,
    HELD,
    LONG,
    DEB_UP
  } btn_state_t;

  // Default sizing used by the bank and its bus interface.
  localparam int DEFAULT_N_BTN           = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_LONG_CYCLES     = 16;

  // Bits needed for a counter that must be able to hold max_count itself.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/button_event_bank_if.sv
// Bundle of per-channel button inputs and event outputs of the event bank.
interface button_event_bank_if
  import button_pkg::*;
#(
  parameter int N_BTN = DEFAULT_N_BTN
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] nc_mask;
  logic [N_BTN-1:0] clear;
  logic [N_BTN-1:0] held;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] long_pulse;
  logic [N_BTN-1:0] press_sticky;
  logic [N_BTN-1:0] long_sticky;

  // Consumer side: drives buttons and clears, observes events.
  modport master (
    output btn_raw, nc_mask, clear,
    input  held, press_pulse, long_pulse, press_sticky, long_sticky
  );

  // Event bank side.
  modport slave (
    input  btn_raw, nc_mask, clear,
    output held, press_pulse, long_pulse, press_sticky, long_sticky
  );

endinterface

// File: rtl/button_channel.sv
// One button channel: debounce, short/long classification, pulses and sticky flags.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic p,
  input  logic clear,
  output logic held,
  output logic press_pulse,
  output logic long_pulse,
  output logic press_sticky,
  output logic long_sticky
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_CYCLES);

  // Counter values at which the next qualifying sample completes a phase.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  // With a single-sample debounce the DEB_DN/DEB_UP states are bypassed.
  localparam bit DEB_SINGLE = (DEBOUNCE_CYCLES == 1);

  btn_state_t        state;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              is_long;

  // Channel FSM with registered outputs; a sticky set later in the block overrides a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      deb_cnt      <= '0;
      hold_cnt     <= '0;
      is_long      <= 1'b0;
      held         <= 1'b0;
      press_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      press_sticky <= 1'b0;
      long_sticky  <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      if (clear) begin
        press_sticky <= 1'b0;
        long_sticky  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (p) begin
            if (DEB_SINGLE) begin
              state    <= HELD;
              held     <= 1'b1;
              hold_cnt <= '0;
              is_long  <= 1'b0;
            end else begin
              state   <= DEB_DN;
              deb_cnt <= DEB_W'(1);
            end
          end
        end
        DEB_DN: begin
          if (!p) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= HELD;
            held     <= 1'b1;
            hold_cnt <= '0;
            is_long  <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!p) begin
            if (DEB_SINGLE) begin
              state        <= IDLE;
              held         <= 1'b0;
              press_pulse  <= 1'b1;
              press_sticky <= 1'b1;
            end else begin
              state   <= DEB_UP;
              deb_cnt <= DEB_W'(1);
            end
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= LONG;
            hold_cnt    <= HOLD_MAX;
            is_long     <= 1'b1;
            long_pulse  <= 1'b1;
            long_sticky <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (!p) begin
            if (DEB_SINGLE) begin
              state <= IDLE;
              held  <= 1'b0;
            end else begin
              state   <= DEB_UP;
              deb_cnt <= DEB_W'(1);
            end
          end
        end
        DEB_UP: begin
          if (p) begin
            state <= is_long ? LONG : HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state <= IDLE;
            held  <= 1'b0;
            if (!is_long) begin
              press_pulse  <= 1'b1;
              press_sticky <= 1'b1;
            end
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_event_bank.sv
// Bank of independent button channels with per-channel normally-closed polarity.
module button_event_bank
  import button_pkg::*;
#(
  parameter int N_BTN           = DEFAULT_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic                clk,
  input  logic                resetn,
  button_event_bank_if.slave  bus
);

  logic [N_BTN-1:0] eff_level;
  logic [N_BTN-1:0] held_vec;
  logic [N_BTN-1:0] press_pulse_vec;
  logic [N_BTN-1:0] long_pulse_vec;
  logic [N_BTN-1:0] press_sticky_vec;
  logic [N_BTN-1:0] long_sticky_vec;

  // A normally-closed channel reads 1 at rest, so flip it to get "1 = pressed".
  assign eff_level = bus.btn_raw ^ bus.nc_mask;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .clk         (clk),
      .resetn      (resetn),
      .p           (eff_level[i]),
      .clear       (bus.clear[i]),
      .held        (held_vec[i]),
      .press_pulse (press_pulse_vec[i]),
      .long_pulse  (long_pulse_vec[i]),
      .press_sticky(press_sticky_vec[i]),
      .long_sticky (long_sticky_vec[i])
    );
  end

  assign bus.held         = held_vec;
  assign bus.press_pulse  = press_pulse_vec;
  assign bus.long_pulse   = long_pulse_vec;
  assign bus.press_sticky = press_sticky_vec;
  assign bus.long_sticky  = long_sticky_vec;

endmodule
